// File: rtl/dispsel_pkg.sv
// rtl/dispsel_pkg.sv - shared constants for the display-select receiver
package dispsel_pkg;

  localparam int CNT_W   = 8;
  localparam int FRAME_W = 4;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_0 = 2'b00;
  localparam mode_t MODE_1 = 2'b01;
  localparam mode_t MODE_2 = 2'b10;
  localparam mode_t MODE_3 = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/dispsel_qual.sv
// rtl/dispsel_qual.sv - candidate register and saturating stability counter
module dispsel_qual
  import dispsel_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic  CLK,
  input  logic  RST,
  input  mode_t d,
  output mode_t candidate,
  output logic  qualified,
  output logic  changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  mode_t            cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (d != cand_q) begin
      cand_d = d;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cand_q <= MODE_0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign candidate = cand_q;
  assign qualified = (cnt_q == CNT_MAX);
  assign changed   = (d != cand_q);

endmodule

// File: rtl/dispsel_rx.sv
// rtl/dispsel_rx.sv - debounces the display-select code and applies it at frame start
module dispsel_rx
  import dispsel_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_FRAMES   = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] D_IN,
  input  logic       FRAME_START,
  output logic [1:0] MODE,
  output logic       MODE_VALID,
  output logic       MODE_CHG
);

  localparam logic [FRAME_W-1:0] HOLD_LAST = FRAME_W'(HOLD_FRAMES);

  mode_t              d_q, d_d;
  mode_t              mode_q, mode_d;
  logic               valid_q, valid_d;
  logic               chg_q, chg_d;
  logic [1:0]         state_q, state_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;

  mode_t candidate;
  logic  qualified;
  logic  changed;
  logic  differs;

  dispsel_qual #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_qual (
    .CLK      (CLK),
    .RST      (RST),
    .d        (d_q),
    .candidate(candidate),
    .qualified(qualified),
    .changed  (changed)
  );

  // Before the first apply every candidate counts as new, even one equal to MODE.
  assign differs = (candidate != mode_q) || !valid_q;

  always_comb begin
    d_d     = D_IN;
    mode_d  = mode_q;
    valid_d = valid_q;
    chg_d   = 1'b0;
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (differs) state_d = ST_QUAL;
      end
      ST_QUAL: begin
        if (qualified && !changed && differs) state_d = ST_PEND;
        else if (!differs)                    state_d = ST_IDLE;
      end
      ST_PEND: begin
        if (changed || !qualified) begin
          state_d = ST_QUAL;
        end else if (FRAME_START) begin
          mode_d  = candidate;
          valid_d = 1'b1;
          chg_d   = 1'b1;
          fcnt_d  = '0;
          state_d = (HOLD_FRAMES == 0) ? ST_IDLE : ST_HOLD;
        end
      end
      default: begin
        if (FRAME_START) begin
          fcnt_d = fcnt_q + 4'd1;
          if (fcnt_d == HOLD_LAST) state_d = (candidate == mode_q) ? ST_IDLE : ST_QUAL;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d_q     <= MODE_0;
      mode_q  <= MODE_0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      state_q <= ST_QUAL;
      fcnt_q  <= '0;
    end else begin
      d_q     <= d_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign MODE       = mode_q;
  assign MODE_VALID = valid_q;
  assign MODE_CHG   = chg_q;

endmodule
